// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit that checks alignment and range, runs one RAM access
// per request and returns a registered, sign/zero-extended response.
module mem_access_unit #(
    parameter logic [31:0] ADDR_LIMIT = 32'd4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_exc,
    output logic [1:0]  resp_exc_code,
    output logic [31:0] resp_badvaddr,
    output logic        ram_we,
    output logic [1:0]  ram_mode,
    output logic [11:0] ram_addr,
    output logic [31:0] ram_din,
    input  logic [31:0] ram_dout
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state;
    logic [2:0] op_q;
    logic [31:0] wdata_q;
    logic we_q;
    logic is_store, is_half, is_word, misaligned;
    logic [1:0] fault_code, mode;
    logic [31:0] load_data;

    always_comb begin
        is_store = req_op >= 3'd5;
        is_half = req_op == 3'd1 || req_op == 3'd4 || req_op == 3'd6;
        is_word = req_op == 3'd2 || req_op == 3'd7;
        misaligned = (is_half && req_addr[0]) || (is_word && req_addr[1:0] != 2'b00);
        fault_code = req_addr >= ADDR_LIMIT ? 2'd3 : misaligned ? (is_store ? 2'd2 : 2'd1) : 2'd0;
        mode = is_word ? 2'd0 : is_half ? 2'd1 : 2'd2;
        load_data = op_q >= 3'd5 ? 32'd0 :
                    op_q == 3'd0 ? {{24{ram_dout[7]}}, ram_dout[7:0]} :
                    op_q == 3'd1 ? {{16{ram_dout[15]}}, ram_dout[15:0]} : ram_dout;
    end

    assign req_ready = state == IDLE;
    // gated by rst so a reset edge during ACCESS never lands a store
    assign ram_we = we_q & ~rst;
    assign ram_din = wdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            op_q <= 3'd0;
            wdata_q <= 32'd0;
            we_q <= 1'b0;
            ram_addr <= 12'd0;
            ram_mode <= 2'd0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_exc <= 1'b0;
            resp_exc_code <= 2'd0;
            resp_badvaddr <= 32'd0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    op_q <= req_op;
                    wdata_q <= req_wdata;
                    if (fault_code != 2'd0) begin
                        state <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= 32'd0;
                        resp_exc <= 1'b1;
                        resp_exc_code <= fault_code;
                        resp_badvaddr <= req_addr;
                    end else begin
                        state <= ACCESS;
                        we_q <= is_store;
                        ram_addr <= req_addr[11:0];
                        ram_mode <= mode;
                    end
                end
                ACCESS: begin
                    state <= RESP;
                    we_q <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_rdata <= load_data;
                    resp_exc <= 1'b0;
                    resp_exc_code <= 2'd0;
                    resp_badvaddr <= 32'd0;
                end
                default: begin
                    state <= IDLE;
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: drives directed and random requests into mem_access_unit with a
// byte-lane RAM attached, and checks every response against a byte-array reference model.
module tb_mem_access_unit;
    localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd3, LHU = 3'd4, SB = 3'd5, SH = 3'd6, SW = 3'd7;

    logic clk = 0, rst = 1;
    logic req_valid = 0, req_ready;
    logic [2:0] req_op = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic resp_valid, resp_exc;
    logic [31:0] resp_rdata, resp_badvaddr;
    logic [1:0] resp_exc_code, ram_mode;
    logic ram_we;
    logic [11:0] ram_addr;
    logic [31:0] ram_din, ram_dout;

    mem_access_unit dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_exc(resp_exc), .resp_exc_code(resp_exc_code), .resp_badvaddr(resp_badvaddr),
        .ram_we(ram_we), .ram_mode(ram_mode), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic exc;
        logic [1:0] code;
        logic [31:0] bad;
        int lat;
        time t;
    } exp_t;

    logic [7:0] mem [4096];
    logic [7:0] ref_mem [4096];
    exp_t exp_q [$];
    exp_t m;
    time resp_t [$];
    int checks = 0, errors = 0, wr_cnt = 0, exp_writes = 0;
    logic [31:0] last_rdata, last_bad;
    logic [1:0] last_code;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // byte-lane RAM: little-endian, zero-extended combinational read
    always @(posedge clk) if (ram_we) begin
        mem[ram_addr] = ram_din[7:0];
        if (ram_mode != 2'd2) mem[ram_addr + 12'd1] = ram_din[15:8];
        if (ram_mode == 2'd0) begin
            mem[ram_addr + 12'd2] = ram_din[23:16];
            mem[ram_addr + 12'd3] = ram_din[31:24];
        end
        wr_cnt++;
    end
    assign ram_dout = ram_mode == 2'd0 ? {mem[ram_addr + 12'd3], mem[ram_addr + 12'd2], mem[ram_addr + 12'd1], mem[ram_addr]} :
                      ram_mode == 2'd1 ? {16'd0, mem[ram_addr + 12'd1], mem[ram_addr]} : {24'd0, mem[ram_addr]};

    task automatic predict(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
        exp_t e;
        int size = (op == LB || op == LBU || op == SB) ? 1 : (op == LW || op == SW) ? 4 : 2;
        bit store = op >= SB;
        logic [31:0] v = 0;
        e.t = $time; e.rdata = 0; e.exc = 0; e.code = 0; e.bad = 0; e.lat = 2;
        if (addr >= 32'd4096) e.code = 2'd3;
        else if (addr % size != 0) e.code = store ? 2'd2 : 2'd1;
        if (e.code != 0) begin
            e.exc = 1; e.bad = addr; e.lat = 1;
        end else if (store) begin
            for (int i = 0; i < size; i++) ref_mem[addr + i] = wd[8*i +: 8];
            exp_writes++;
        end else begin
            for (int i = 0; i < size; i++) v = v + (32'(ref_mem[addr + i]) << (8 * i));
            if (op == LB && v >= 128) v = v - 32'd256;
            if (op == LH && v >= 32768) v = v - 32'd65536;
            e.rdata = v;
        end
        exp_q.push_back(e);
    endtask

    always @(negedge clk) if (resp_valid) begin
        resp_t.push_back($time);
        last_rdata = resp_rdata; last_code = resp_exc_code; last_bad = resp_badvaddr;
        if (exp_q.size() == 0) check("spurious_resp", 32'(resp_valid), 0);
        else begin
            m = exp_q.pop_front();
            check("rdata", resp_rdata, m.rdata);
            check("exc", 32'(resp_exc), 32'(m.exc));
            check("exc_code", 32'(resp_exc_code), 32'(m.code));
            check("badvaddr", resp_badvaddr, m.bad);
            check("latency", 32'(($time - m.t + 5) / 10), 32'(m.lat));
            check("writes", 32'(wr_cnt), 32'(exp_writes));
        end
    end

    // called at a negedge; returns at the negedge after acceptance
    task automatic send(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd, input bit hold);
        int n = 0;
        req_op = op; req_addr = addr; req_wdata = wd; req_valid = 1;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        if (!req_ready) begin
            check("ready_timeout", 32'(req_ready), 1);
            req_valid = 0;
            return;
        end
        @(posedge clk);
        predict(op, addr, wd);
        @(negedge clk);
        if (!hold) req_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin @(negedge clk); n++; end
        check("drain", 32'(exp_q.size()), 0);
    endtask

    initial begin
        logic [7:0] b;
        for (int i = 0; i < 4096; i++) begin
            b = 8'($urandom);
            mem[i] = b;
            ref_mem[i] = b;
        end
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(req_ready), 1);
        check("rst_resp_valid", 32'(resp_valid), 0);
        check("rst_rdata", resp_rdata, 0);
        check("rst_exc", 32'(resp_exc), 0);
        check("rst_code", 32'(resp_exc_code), 0);
        check("rst_bad", resp_badvaddr, 0);
        check("rst_we", 32'(ram_we), 0);
        check("rst_mode", 32'(ram_mode), 0);
        check("rst_addr", 32'(ram_addr), 0);
        rst = 0;
        @(negedge clk);

        send(SW, 32'h040, 32'hDEADBEEF, 0); send(LW, 32'h040, 0, 0); drain();
        check("lw_word", last_rdata, 32'hDEADBEEF);
        send(SB, 32'h003, 32'h000000A5, 0); send(LB, 32'h003, 0, 0); drain();
        check("lb_sext", last_rdata, 32'hFFFFFFA5);
        send(LBU, 32'h003, 0, 0); drain();
        check("lbu_zext", last_rdata, 32'h000000A5);
        send(LW, 32'h000, 0, 0); drain();
        check("lw_lane3", 32'(last_rdata[31:24]), 32'hA5);
        send(SH, 32'h012, 32'h00008001, 0); send(LH, 32'h012, 0, 0); drain();
        check("lh_sext", last_rdata, 32'hFFFF8001);
        send(LHU, 32'h012, 0, 0); send(LH, 32'h010, 0, 0); drain();
        send(SH, 32'h011, 32'hCAFE, 0); drain();
        check("sh_mis_code", 32'(last_code), 2);
        check("sh_mis_bad", last_bad, 32'h011);
        send(LW, 32'h1000, 0, 0); drain();
        check("lw_range_code", 32'(last_code), 3);
        check("lw_range_bad", last_bad, 32'h1000);
        send(SB, 32'hFFF, 32'h5A, 0); send(LB, 32'hFFF, 0, 0); send(LH, 32'hFFE, 0, 0);
        send(LW, 32'hFFC, 0, 0); send(LH, 32'h003, 0, 0); drain();

        // reset while the store is in ACCESS
        req_op = SW; req_addr = 32'h080; req_wdata = 32'h12345678; req_valid = 1;
        check("rst_acc_idle", 32'(req_ready), 1);
        @(posedge clk); @(negedge clk);
        check("rst_acc_we_on", 32'(ram_we), 1);
        rst = 1; req_valid = 0;
        #1 check("rst_acc_we_forced", 32'(ram_we), 0);
        @(posedge clk); @(negedge clk);
        check("rst_acc_ready", 32'(req_ready), 1);
        rst = 0;
        repeat (3) @(negedge clk);
        check("rst_acc_ready2", 32'(req_ready), 1);
        check("rst_acc_nowrite", 32'(wr_cnt), 32'(exp_writes));
        send(LW, 32'h080, 0, 0); drain();

        // reset while a fault response is showing
        send(LW, 32'h2000, 0, 0);
        check("rst_resp_on", 32'(resp_valid), 1);
        rst = 1;
        @(posedge clk); @(negedge clk);
        check("rst_resp_cut", 32'(resp_valid), 0);
        check("rst_resp_ready", 32'(req_ready), 1);
        rst = 0;
        @(negedge clk);
        check("rst_resp_ready2", 32'(req_ready), 1);
        drain();

        resp_t.delete();
        send(SW, 32'h100, 32'h11C35577, 1); send(LW, 32'h100, 0, 1);
        send(LB, 32'h102, 0, 1); send(SB, 32'h104, 32'h7F, 0); drain();
        check("stream_cnt", 32'(resp_t.size()), 4);
        for (int i = 1; i < resp_t.size(); i++) check("stream_gap", 32'(resp_t[i] - resp_t[i-1]), 30);

        for (int k = 0; k < 80; k++) begin
            logic [31:0] a;
            case ($urandom_range(0, 3))
                0: a = $urandom_range(0, 63);
                1: a = 32'hFF0 + $urandom_range(0, 31);
                2: a = $urandom;
                default: a = $urandom_range(0, 4095);
            endcase
            send(3'($urandom_range(0, 7)), a, $urandom, k != 79 && $urandom_range(0, 1) == 1);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store unit between the MEM pipeline stage and the byte-lane data RAM (4 KiB, word/half/byte modes, zero-extended read data). It accepts one memory request per handshake, checks alignment and range, drives the RAM's `we`/`mode`/address/data for one access cycle, and sign- or zero-extends load data. It returns a registered response with an exception code and the faulting virtual address.

## Interface
Parameters:
- `ADDR_LIMIT`, 4096: first byte address outside the RAM; requests at or above it fault.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request; high only in IDLE.
- `req_op`  in  3  operation: 0 LB, 1 LH, 2 LW, 3 LBU, 4 LHU, 5 SB, 6 SH, 7 SW.
- `req_addr`  in  32  byte virtual address.
- `req_wdata`  in  32  store data. Byte is in [7:0]; half is in [15:0].
- `resp_valid`  out  1  one-cycle response strobe.
- `resp_rdata`  out  32  extended load data; 0 for stores and faults.
- `resp_exc`  out  1  request faulted.
- `resp_exc_code`  out  2  0 none, 1 load misaligned (AdEL), 2 store misaligned (AdES), 3 out of range.
- `resp_badvaddr`  out  32  faulting address; 0 when `resp_exc`=0.
- `ram_we`  out  1  RAM write enable.
- `ram_mode`  out  2  RAM mode: 0 word, 1 halfword, 2 byte.
- `ram_addr`  out  12  RAM byte address, equal to `req_addr[11:0]`.
- `ram_din`  out  32  RAM write data, equal to `req_wdata` unchanged.
- `ram_dout`  in  32  RAM read data. It is combinational on `ram_addr`/`ram_mode` and zero-extended.

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch op, addr and wdata.
  - Evaluate the fault condition:
    - Range check first: addr ≥ `ADDR_LIMIT` gives code 3.
    - Otherwise halfword ops with addr[0]≠0, or word ops with addr[1:0]≠0, give code 1 for loads and code 2 for stores.
  - Fault → go to RESP with `resp_exc`=1. No RAM cycle is issued.
  - No fault → go to ACCESS.
- ACCESS:
  - `ram_addr`/`ram_mode` come from the latched request. Mode is 0 for LW/SW, 1 for LH/LHU/SH, 2 for LB/LBU/SB.
  - Stores: `ram_we`=1 for exactly this cycle; the write lands on the edge that leaves ACCESS.
  - Loads: capture `ram_dout` on that edge.
    - LB: replicate bit 7 into [31:8].
    - LH: replicate bit 15 into [31:16].
    - LBU/LHU/LW: pass through.
  - Always go to RESP.
- RESP: `resp_valid`=1 with registered rdata/exc fields, then go to IDLE.
- `ram_we`=0 in every state except ACCESS. It is also forced to 0 whenever `rst`=1, so no write happens on a reset edge.
- Outside ACCESS, `ram_addr`/`ram_mode` hold their last values (reset value 0); they have no effect while `ram_we`=0.

## Timing
- Request accepted at edge N (IDLE, `req_valid`=1):
  - No fault: ACCESS during cycle N+1, `resp_valid` high during cycle N+2.
  - Fault: `resp_valid` high during cycle N+1.
- `req_ready` is 0 in ACCESS and RESP. Throughput is one request per 3 cycles, or per 2 cycles if faulting.
- `resp_*` fields are valid only while `resp_valid`=1. They hold their values until the next response.
- Reset values:
  - State: IDLE.
  - `req_ready`=1.
  - 0: `resp_valid`, `resp_rdata`, `resp_exc`, `resp_exc_code`, `resp_badvaddr`, `ram_we`, `ram_mode`, `ram_addr`.
- Reset mid-operation:
  - In ACCESS: the store is dropped (no RAM write) and no response is issued.
  - In RESP: the response is cut off.
  - In both cases the unit is in IDLE with `req_ready`=1 the cycle after reset deasserts.
- Holding `req_valid` high continuously: a new request is accepted on each IDLE edge, and no request is lost or duplicated.
- Address 0xFFF with a byte op is legal. Address 0xFFE with LH is legal. Address 0xFFC with LW is legal.

## Test plan
- SW 0xDEADBEEF @0x040, then LW @0x040 → `resp_rdata`=0xDEADBEEF, `resp_exc`=0. `resp_valid` comes 2 cycles after each accept.
- SB 0x000000A5 @0x003, then LB @0x003 → 0xFFFFFFA5. LBU @0x003 → 0x000000A5. LW @0x000 → bits [31:24]=0xA5, other bytes unchanged.
- SH 0x00008001 @0x012, then LH @0x012 → 0xFFFF8001. LHU → 0x00008001. LH @0x010 → prior half unchanged.
- SH @0x011 → code 2, badvaddr 0x011, `ram_we` never asserted, `resp_valid` 1 cycle after accept. LW @0x1000 → code 3, badvaddr 0x1000.
- SW 0x12345678 @0x080 with `rst` asserted during ACCESS → no `resp_valid`, `req_ready`=1 after reset. LW @0x080 returns the pre-existing value.
- `req_valid` held high for 4 requests (SW, LW, LB, SB) → exactly 4 `resp_valid` pulses, spaced 3 cycles apart, in order, with correct data.
